// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding uart_tx, drained on baud_x1 ticks when tx_ready.
// Define UART_TX_FIFO_CRLF_EN to send a CR before every stored LF.
module uart_tx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  input  logic                  clear_ovf,
  input  logic                  baud_x1,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_strobe
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_LVL =
    (ADDR_WIDTH+1)'(AFULL_LEVEL);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] head, data_n;
  logic                  push, pop, strobe_n;

`ifdef UART_TX_FIFO_CRLF_EN
  localparam logic [DATA_WIDTH-1:0] LF =
    DATA_WIDTH'(8'h0A);
  localparam logic [DATA_WIDTH-1:0] CR =
    DATA_WIDTH'(8'h0D);
  logic cr_pending, cr_n;
`endif

  assign level       = wr_ptr - rd_ptr;
  assign empty       = (level == '0);
  assign full        = (level == FULL_LVL);
  assign almost_full = (level >= AFULL_LVL);
  assign push        = wr_en && !full;
  assign head        = mem[rd_ptr[ADDR_WIDTH-1:0]];

  always_comb begin
    state_n  = state;
    strobe_n = tx_strobe;
    data_n   = tx_data;
    pop      = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
    cr_n     = cr_pending;
`endif
    if (baud_x1) begin
      unique case (state)
        IDLE: begin
          if (!empty && tx_ready) begin
            strobe_n = 1'b1;
            state_n  = SEND;
`ifdef UART_TX_FIFO_CRLF_EN
            // CR goes out first; the LF stays queued
            if (head == LF && !cr_pending) begin
              data_n = CR;
              cr_n   = 1'b1;
            end else begin
              data_n = head;
              pop    = 1'b1;
              cr_n   = 1'b0;
            end
`else
            data_n = head;
            pop    = 1'b1;
`endif
          end
        end
        SEND: begin
          strobe_n = 1'b0;
          state_n  = GAP;
        end
        GAP: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tx_strobe <= 1'b0;
      tx_data   <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      tx_strobe <= strobe_n;
      tx_data   <= data_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // a drop in the same clk beats the clear
      if (wr_en && full)  overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

`ifdef UART_TX_FIFO_CRLF_EN
  always_ff @(posedge clk) begin
    if (reset) cr_pending <= 1'b0;
    else       cr_pending <= cr_n;
  end
`endif

  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, directed corners,
// then random traffic against a queue-based reference.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full, almost_full, empty;
  logic [4:0] level;
  logic       overflow;
  logic       clear_ovf;
  logic       baud_x1;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_strobe;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .AFULL_LEVEL(12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .full       (full),
    .almost_full(almost_full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf),
    .baud_x1    (baud_x1),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_strobe  (tx_strobe)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference: stored words, sender busy countdown, outputs
  logic [7:0] q[$];
  int         busy_ticks = 0;
  logic       m_strobe = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_cr = 1'b0;

  logic [7:0] seen[$];
  logic       prev_s = 1'b0;

  function automatic void chk(input string nm,
                              input int act,
                              input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endfunction

  function automatic void model(input logic r,
                                input logic we,
                                input logic [7:0] wd,
                                input logic co,
                                input logic bd,
                                input logic rdy);
    logic was_full;
    if (r) begin
      q.delete();
      busy_ticks = 0;
      m_strobe = 1'b0;
      m_data = 8'h00;
      m_ovf = 1'b0;
      m_cr = 1'b0;
      return;
    end
    was_full = (q.size() == 16);
    if (bd) begin
      if (busy_ticks > 0) begin
        busy_ticks--;
        m_strobe = 1'b0;
      end else if (q.size() > 0 && rdy) begin
`ifdef UART_TX_FIFO_CRLF_EN
        if (q[0] == 8'h0A && !m_cr) begin
          m_data = 8'h0D;
          m_cr = 1'b1;
        end else begin
          m_data = q.pop_front();
          m_cr = 1'b0;
        end
`else
        m_data = q.pop_front();
`endif
        m_strobe = 1'b1;
        busy_ticks = 2;
      end
    end
    if (we && !was_full) q.push_back(wd);
    if (we && was_full) m_ovf = 1'b1;
    else if (co) m_ovf = 1'b0;
  endfunction

  task automatic step(input logic r,
                      input logic we,
                      input logic [7:0] wd,
                      input logic co,
                      input logic bd,
                      input logic rdy);
    @(negedge clk);
    reset = r;
    wr_en = we;
    wr_data = wd;
    clear_ovf = co;
    baud_x1 = bd;
    tx_ready = rdy;
    @(posedge clk);
    model(r, we, wd, co, bd, rdy);
    #1;
    chk("level", int'(level), q.size());
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("full", int'(full), int'(q.size() == 16));
    chk("almost_full", int'(almost_full),
        int'(q.size() >= 12));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("tx_strobe", int'(tx_strobe), int'(m_strobe));
    chk("tx_data", int'(tx_data), int'(m_data));
    if (tx_strobe && !prev_s) seen.push_back(tx_data);
    prev_s = tx_strobe;
  endtask

  typedef struct {
    logic       r, we;
    logic [7:0] wd;
    logic       co, bd, rdy;
    int         lvl;
    logic       st;
    logic [7:0] dt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic we,
                              input logic [7:0] wd,
                              input logic co, input logic bd,
                              input logic rdy, input int lvl,
                              input logic st,
                              input logic [7:0] dt);
    vec_t v;
    v.r = r; v.we = we; v.wd = wd; v.co = co;
    v.bd = bd; v.rdy = rdy; v.lvl = lvl;
    v.st = st; v.dt = dt;
    return v;
  endfunction

  initial begin
    logic [7:0] nxt;
    int         bad;
    int         cnt;

    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    clear_ovf = 1'b0; baud_x1 = 1'b0; tx_ready = 1'b0;

    // three words queued, then drained one per 3 ticks
    tbl.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,0,1'b0,8'h00));
    tbl.push_back(mk(1'b0,1'b1,8'h41,1'b0,1'b0,1'b1,1,1'b0,8'h00));
    tbl.push_back(mk(1'b0,1'b1,8'h42,1'b0,1'b0,1'b1,2,1'b0,8'h00));
    tbl.push_back(mk(1'b0,1'b1,8'h43,1'b0,1'b0,1'b1,3,1'b0,8'h00));
    tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,2,1'b1,8'h41));
    tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,2,1'b0,8'h41));
    tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,2,1'b0,8'h41));
    tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1,1'b1,8'h42));
    tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1,1'b0,8'h42));
    tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1,1'b0,8'h42));
    tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,0,1'b1,8'h43));
    tbl.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,0,1'b0,8'h43));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].we, tbl[i].wd,
           tbl[i].co, tbl[i].bd, tbl[i].rdy);
      chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].lvl);
      chk($sformatf("tbl%0d_empty", i), int'(empty),
          int'(tbl[i].lvl == 0));
      chk($sformatf("tbl%0d_strobe", i), int'(tx_strobe),
          int'(tbl[i].st));
      chk($sformatf("tbl%0d_data", i), int'(tx_data),
          int'(tbl[i].dt));
    end

    // fill past capacity with the sender stalled
    for (int i = 0; i < 17; i++)
      step(1'b0, 1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
    chk("fill_level", int'(level), 16);
    chk("fill_full", int'(full), 1);
    chk("fill_ovf", int'(overflow), 1);

    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("clr_ovf", int'(overflow), 0);
    step(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    chk("clr_vs_drop", int'(overflow), 1);

    // full FIFO drained while writer pushes continuously
    seen.delete();
    nxt = 8'h10;
    for (int i = 0; i < 160; i++) begin
      logic acc;
      acc = (q.size() < 16);
      step(1'b0, 1'b1, nxt, 1'b0, 1'b1, 1'b1);
      if (acc) nxt++;
    end
    chk("wrap_count_ok", int'(seen.size() >= 40), 1);
    bad = 0;
    foreach (seen[i])
      if (seen[i] != 8'(i)) bad++;
    chk("wrap_sequence", bad, 0);

    for (int i = 0; i < 60; i++)
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("drained", int'(empty), 1);

    // LF handling
    seen.delete();
    step(1'b0, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
`ifdef UART_TX_FIFO_CRLF_EN
    chk("lf_count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("lf_first", int'(seen[0]), 8'h0D);
      chk("lf_second", int'(seen[1]), 8'h0A);
    end
`else
    chk("lf_count", seen.size(), 1);
    if (seen.size() == 1)
      chk("lf_only", int'(seen[0]), 8'h0A);
`endif
    chk("lf_empty", int'(empty), 1);

    // reset while a word is being strobed
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("pre_rst_strobe", int'(tx_strobe), 1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("rst_strobe", int'(tx_strobe), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    cnt = seen.size();
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("rst_no_strobes", seen.size(), cnt);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 5) == 0) ? 8'h0A
                                      : 8'($urandom);
      step(1'b0 || ($urandom_range(0, 499) == 0),
           1'($urandom_range(0, 2) != 0), d,
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
